// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// Define UART_ARB_FIXED_PRIO_EN to replace round-robin with lowest-index-wins priority.
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_LEN      = 8,
    parameter int START_TIMEOUT = 16,
    localparam int IDX_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*DATA_LEN-1:0]  req_data,
    output logic [NUM_REQ-1:0]           gnt,
    output logic [DATA_LEN-1:0]          tx_data,
    output logic                         tx_start,
    input  logic                         tx_empty,
    output logic                         busy,
    output logic [IDX_W-1:0]             owner,
    output logic                         timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_BUSY = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(START_TIMEOUT - 1);

    state_t                state_r;
    logic [7:0]            cnt_r;
    logic [IDX_W-1:0]      win_s;
    logic [DATA_LEN-1:0]   win_data_s;
`ifndef UART_ARB_FIXED_PRIO_EN
    logic [IDX_W-1:0]      ptr_r;
`endif

    // Winner selection: the lowest search distance with a set request wins.
    always_comb begin
        logic [IDX_W-1:0] idx_v;
        idx_v = '0;
        win_s = '0;
`ifdef UART_ARB_FIXED_PRIO_EN
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx_v = IDX_W'(k);
            if (req[idx_v]) begin
                win_s = idx_v;
            end else begin
                win_s = win_s;
            end
        end
`else
        // Walk from farthest to nearest so the nearest set bit after ptr_r overwrites last.
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx_v = IDX_W'((int'(ptr_r) + k) % NUM_REQ);
            if (req[idx_v]) begin
                win_s = idx_v;
            end else begin
                win_s = win_s;
            end
        end
`endif
    end

    // Byte multiplexer for the selected requester.
    always_comb begin
        win_data_s = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (win_s == IDX_W'(k)) begin
                win_data_s = req_data[k*DATA_LEN +: DATA_LEN];
            end else begin
                win_data_s = win_data_s;
            end
        end
    end

    // Grant/frame-tracking FSM with registered outputs; pulses default low every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            gnt         <= '0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            busy        <= 1'b0;
            owner       <= '0;
            timeout_err <= 1'b0;
            cnt_r       <= 8'd0;
`ifndef UART_ARB_FIXED_PRIO_EN
            ptr_r       <= IDX_W'(NUM_REQ - 1);
`endif
        end else begin
            gnt         <= '0;
            tx_start    <= 1'b0;
            timeout_err <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if ((|req) && tx_empty) begin
                        tx_data  <= win_data_s;
                        gnt      <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_s;
                        tx_start <= 1'b1;
                        owner    <= win_s;
                        busy     <= 1'b1;
                        cnt_r    <= 8'd0;
`ifndef UART_ARB_FIXED_PRIO_EN
                        ptr_r    <= win_s;
`endif
                        state_r  <= ST_WAIT_BUSY;
                    end
                end
                ST_WAIT_BUSY: begin
                    if (!tx_empty) begin
                        state_r <= ST_WAIT_DONE;
                    end else if (cnt_r == TO_LAST) begin
                        // Transmitter never started: drop the byte, pointer already moved past owner.
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (tx_empty) begin
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NUM_REQ=4, DATA_LEN=8, START_TIMEOUT=16).
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_empty;
    logic        busy;
    logic [1:0]  owner;
    logic        timeout_err;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef UART_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    uart_tx_arbiter #(.NUM_REQ(4), .DATA_LEN(8), .START_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
        .tx_data(tx_data), .tx_start(tx_start), .tx_empty(tx_empty),
        .busy(busy), .owner(owner), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input int i);
        logic [31:0] d;
        d = 32'h443322A5;
        return d[i*8 +: 8];
    endfunction

    // Wait for a grant, check it, then play one transmitter frame back to IDLE.
    task automatic grant_frame(input string tag, input int exp_idx);
        for (int i = 0; i < 8; i++) begin
            if (gnt != 4'd0) break;
            tick();
        end
        chk({tag, "_gnt"},   32'(gnt),      32'(4'd1 << exp_idx));
        chk({tag, "_owner"}, 32'(owner),    32'(exp_idx));
        chk({tag, "_data"},  32'(tx_data),  32'(byte_of(exp_idx)));
        chk({tag, "_start"}, 32'(tx_start), 32'd1);
        tick();
        chk({tag, "_gnt_pulse"}, 32'(gnt), 32'd0);
        tx_empty = 1'b0;
        tick();
        tick();
        tx_empty = 1'b1;
        tick();
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1; req = 4'd0; req_data = 32'h443322A5; tx_empty = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_start", 32'(tx_start), 32'd0);
        chk("rst_data", 32'(tx_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_to", 32'(timeout_err), 32'd0);

        // Single request, basic frame
        req = 4'b0001;
        tick();
        chk("t1_gnt", 32'(gnt), 32'd1);
        chk("t1_start", 32'(tx_start), 32'd1);
        chk("t1_data", 32'(tx_data), 32'hA5);
        chk("t1_owner", 32'(owner), 32'd0);
        chk("t1_busy", 32'(busy), 32'd1);
        req = 4'b0000;
        tick();
        chk("t1_gnt_pulse", 32'(gnt), 32'd0);
        chk("t1_start_pulse", 32'(tx_start), 32'd0);
        tx_empty = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("t1_busy_mid", 32'(busy), 32'd1);
        tx_empty = 1'b1;
        chk("t1_busy_at_rise", 32'(busy), 32'd1);
        tick();
        chk("t1_busy_fall", 32'(busy), 32'd0);

        // All requesters active from fresh reset: rotating owners
        rst = 1'b1; tick(); rst = 1'b0;
        req = 4'b1111;
        grant_frame("rr0", 0);
        grant_frame("rr1", FIXED ? 0 : 1);
        grant_frame("rr2", FIXED ? 0 : 2);
        grant_frame("rr3", FIXED ? 0 : 3);
        grant_frame("rr4", 0);
        grant_frame("rr5", FIXED ? 0 : 1);
        req = 4'b0000;
        tick();

        // req=1010 held; pointer now at 1
        req = 4'b1010;
        grant_frame("p0", FIXED ? 1 : 3);
        grant_frame("p1", 1);
        grant_frame("p2", FIXED ? 1 : 3);
        req = 4'b0000;
        tick();

        // Start timeout: tx_empty never falls
        req = 4'b0011;
        tick();
        chk("to_gnt", 32'(gnt), 32'd1);
        for (int i = 0; i < 15; i++) tick();
        chk("to_early", 32'(timeout_err), 32'd0);
        chk("to_busy_early", 32'(busy), 32'd1);
        tick();
        chk("to_pulse", 32'(timeout_err), 32'd1);
        chk("to_busy", 32'(busy), 32'd0);
        tick();
        chk("to_pulse_end", 32'(timeout_err), 32'd0);
        chk("to_next_gnt", 32'(gnt), FIXED ? 32'd1 : 32'd2);

        // Reset during WAIT_DONE
        req = 4'b0000; tx_empty = 1'b0;
        tick(); tick();
        chk("wd_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("wr_gnt", 32'(gnt), 32'd0);
        chk("wr_busy", 32'(busy), 32'd0);
        chk("wr_owner", 32'(owner), 32'd0);
        chk("wr_data", 32'(tx_data), 32'd0);
        chk("wr_start", 32'(tx_start), 32'd0);
        req = 4'b0001;
        tick(); tick(); tick();
        chk("wr_hold_gnt", 32'(gnt), 32'd0);
        tx_empty = 1'b1;
        tick();
        chk("wr_gnt_after", 32'(gnt), 32'd1);

        // Request arriving during WAIT_DONE waits for IDLE
        req = 4'b0000;
        tick();
        tx_empty = 1'b0;
        tick();
        req = 4'b0100;
        tick(); tick();
        chk("wd_hold_gnt", 32'(gnt), 32'd0);
        tx_empty = 1'b1;
        tick();
        chk("wd_idle_gnt", 32'(gnt), 32'd0);
        chk("wd_idle_busy", 32'(busy), 32'd0);
        tick();
        chk("wd_gnt", 32'(gnt), 32'b0100);
        chk("wd_owner", 32'(owner), 32'd2);
        chk("wd_data", 32'(tx_data), 32'h33);
        req = 4'b0000;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
